wb_result_arbiter: RTL

- Round-robin arbiter sharing one 64-bit result/writeback path among 8 ALU-side producers (adder, shifter, logic unit, multiplier, etc.).
- Picks one valid requester per cycle, drives the 3-bit select of the 64-bit 8:1 result mux, and registers the selected result into a single-entry output stage.
- Valid/ready handshake toward the pipeline writeback stage.

---
 rtl/wb_arb_pkg.sv | 11 +
 rtl/rr_pick8.sv | 29 ++
 rtl/wb_result_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared sizes and output-stage state encoding for the writeback arbiter
package wb_arb_pkg;
    localparam int NREQ = 8;
    localparam int DW   = 64;
    localparam int SELW = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;
endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational 8-way round-robin pick starting just after the last grant
module rr_pick8
    import wb_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] grant_idx,
    output logic [NREQ-1:0] grant_onehot
);
    logic [SELW-1:0]   start;
    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [SELW-1:0]   offset;

    always_comb begin
        start   = ptr + 3'd1;
        // Rotate so bit 0 is the highest-priority requester, encode, then rotate back.
        doubled = {req_valid, req_valid} >> start;
        rotated = doubled[NREQ-1:0];
        offset  = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rotated[j]) offset = 3'(j);
        end
        any          = |req_valid;
        grant_idx    = start + offset;
        grant_onehot = any ? (8'd1 << grant_idx) : 8'd0;
    end
endmodule

// File: rtl/wb_result_arbiter.sv
// rtl/wb_result_arbiter.sv - round-robin arbiter feeding one registered 64-bit writeback slot
module wb_result_arbiter
    import wb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               flush,
    output logic [SELW-1:0]    sel,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SELW-1:0]    out_src,
    input  logic               out_ready
);
    out_state_t      state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] sel_q;
    logic            any;
    logic [SELW-1:0] grant_idx;
    logic [NREQ-1:0] grant_onehot;
    logic            can_accept;
    logic            grant;
    logic [DW-1:0]   picked;

    rr_pick8 u_pick (
        .req_valid    (req_valid),
        .ptr          (ptr),
        .any          (any),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    assign can_accept = ((state == ST_EMPTY) || out_ready) && !flush;
    assign grant      = can_accept && any && !rst;
    assign req_ready  = grant ? grant_onehot : '0;
    // Hold the mux select at the last grant when idle so the mux input stays quiet.
    assign sel        = grant ? grant_idx : sel_q;
    assign out_valid  = (state == ST_FULL);

    always_comb begin
        picked = '0;
        case (grant_idx)
            3'd0: picked = req_data[0*DW +: DW];
            3'd1: picked = req_data[1*DW +: DW];
            3'd2: picked = req_data[2*DW +: DW];
            3'd3: picked = req_data[3*DW +: DW];
            3'd4: picked = req_data[4*DW +: DW];
            3'd5: picked = req_data[5*DW +: DW];
            3'd6: picked = req_data[6*DW +: DW];
            3'd7: picked = req_data[7*DW +: DW];
            default: picked = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= '0;
            ptr      <= 3'd7;
            sel_q    <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (grant) begin
            state    <= ST_FULL;
            out_data <= picked;
            out_src  <= grant_idx;
            ptr      <= grant_idx;
            sel_q    <= grant_idx;
        end else if (state == ST_FULL && out_ready) begin
            state <= ST_EMPTY;
        end
    end
endmodule
